// File: rtl/uart_transmitter8.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
// tx is registered; tx_ready/busy/tx_done decode from the state and counter registers.
module uart_transmitter8 #(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_MAX = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, n_state;
    logic [CW-1:0] cnt, n_cnt;
    logic [2:0]    idx, n_idx;
    logic [7:0]    sr, n_sr;
    logic          par, n_par;
    logic          n_tx;
    logic          bit_end;

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign bit_end  = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sr    <= '0;
            par   <= 1'b0;
            tx    <= 1'b1;
        end else begin
            state <= n_state;
            cnt   <= n_cnt;
            idx   <= n_idx;
            sr    <= n_sr;
            par   <= n_par;
            tx    <= n_tx;
        end
    end

    always_comb begin
        n_state = state;
        n_cnt   = cnt;
        n_idx   = idx;
        n_sr    = sr;
        n_par   = par;
        n_tx    = tx;
        tx_done = 1'b0;
        case (state)
            IDLE: begin
                n_tx = 1'b1;
                if (tx_valid) begin
                    n_state = START;
                    n_sr    = data_in;
                    n_par   = (^data_in) ^ (PARITY_ODD != 0);
                    n_tx    = 1'b0;
                    n_cnt   = '0;
                    n_idx   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    n_state = DATA;
                    n_cnt   = '0;
                    n_tx    = sr[0];
                end else begin
                    n_cnt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    n_cnt = '0;
                    if (idx == 3'd7) begin
                        n_idx = '0;
                        if (PARITY_EN != 0) begin
                            n_state = PARITY;
                            n_tx    = par;
                        end else begin
                            n_state = STOP;
                            n_tx    = 1'b1;
                        end
                    end else begin
                        // shift register keeps the bit on the line in sr[0]
                        n_idx = idx + 1'b1;
                        n_sr  = sr >> 1;
                        n_tx  = sr[1];
                    end
                end else begin
                    n_cnt = cnt + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    n_state = STOP;
                    n_cnt   = '0;
                    n_idx   = '0;
                    n_tx    = 1'b1;
                end else begin
                    n_cnt = cnt + 1'b1;
                end
            end
            STOP: begin
                n_tx = 1'b1;
                if (bit_end) begin
                    n_cnt = '0;
                    if (idx == STOP_MAX) begin
                        tx_done = 1'b1;
                        n_state = IDLE;
                        n_idx   = '0;
                    end else begin
                        n_idx = idx + 1'b1;
                    end
                end else begin
                    n_cnt = cnt + 1'b1;
                end
            end
            default: begin
                n_state = IDLE;
                n_tx    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_transmitter8.sv
// Four transmitter configurations driven from a byte table; a per-cycle scoreboard
// holds the expected {tx, busy, tx_done, tx_ready} for every cycle of each frame.
module tb_uart_transmitter8;
    localparam int N = 4;
    localparam int CPB [N] = '{1, 1, 1, 4};
    localparam int PE  [N] = '{0, 1, 1, 0};
    localparam int ODD [N] = '{0, 0, 1, 0};
    localparam int SB  [N] = '{1, 1, 1, 2};

    typedef struct {
        logic tx;
        logic busy;
        logic done;
        logic rdy;
    } exp_t;

    typedef struct {
        int         k;
        logic [7:0] d;
        logic       par;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0][7:0]   din = '0;
    logic [N-1:0]        vld = '0;
    logic [N-1:0]        rdy, txl, bsy, dne;

    exp_t sb [N][$];
    int   exp_done [N];
    int   ndone [N];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_transmitter8 #(
            .CLKS_PER_BIT(CPB[g]), .PARITY_EN(PE[g]),
            .PARITY_ODD(ODD[g]), .STOP_BITS(SB[g])
        ) u_dut (
            .clk(clk), .rst(rst), .data_in(din[g]), .tx_valid(vld[g]),
            .tx_ready(rdy[g]), .tx(txl[g]), .busy(bsy[g]), .tx_done(dne[g])
        );
    end

    function automatic void push_rec(int k, logic t, logic b, logic d, logic r);
        exp_t e;
        e.tx = t; e.busy = b; e.done = d; e.rdy = r;
        sb[k].push_back(e);
    endfunction

    // Model: expected line level per cycle for a whole frame, then one idle cycle.
    function automatic void push_frame(int k, logic [7:0] d, logic par);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (PE[k] != 0) bits.push_back(par);
        for (int s = 0; s < SB[k]; s++) bits.push_back(1'b1);
        for (int i = 0; i < bits.size(); i++)
            for (int c = 0; c < CPB[k]; c++)
                push_rec(k, bits[i], 1'b1, (i == bits.size() - 1) && (c == CPB[k] - 1), 1'b0);
        push_rec(k, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_done[k]++;
    endfunction

    task automatic send(int k, logic [7:0] d, logic par, logic hold);
        int t;
        @(posedge clk); #1;
        din[k] = d;
        vld[k] = 1'b1;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (rdy[k]) break;
        end
        checks++;
        if (t == 200) begin
            failures++;
            $display("FAIL ready_timeout k=%0d tx_ready=%b required 1", k, rdy[k]);
            vld[k] = 1'b0;
        end else begin
            @(posedge clk);
            push_frame(k, d, par);
            #1;
            if (!hold) vld[k] = 1'b0;
        end
    endtask

    task automatic drain(int k);
        int t;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (sb[k].size() == 0) break;
        end
        checks++;
        if (t == 300) begin
            failures++;
            $display("FAIL drain_timeout k=%0d pending=%0d required 0", k, sb[k].size());
        end
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{0, 8'hA5, 1'b0};
        vecs[1] = '{0, 8'h3C, 1'b0};
        vecs[2] = '{0, 8'h00, 1'b0};
        vecs[3] = '{0, 8'hFF, 1'b0};
        vecs[4] = '{1, 8'h07, 1'b1};
        vecs[5] = '{2, 8'h07, 1'b0};
        vecs[6] = '{1, 8'hFF, 1'b0};
        vecs[7] = '{2, 8'h00, 1'b1};
        vecs[8] = '{3, 8'h01, 1'b0};
        vecs[9] = '{1, 8'h80, 1'b1};
        for (int k = 0; k < N; k++) begin
            exp_done[k] = 0;
            ndone[k] = 0;
        end

        fork
            forever begin
                @(negedge clk);
                for (int k = 0; k < N; k++) begin
                    if (dne[k] === 1'b1) ndone[k]++;
                    if (sb[k].size() > 0) begin
                        exp_t e;
                        e = sb[k].pop_front();
                        checks++;
                        if ({txl[k], bsy[k], dne[k], rdy[k]} !== {e.tx, e.busy, e.done, e.rdy}) begin
                            failures++;
                            $display("FAIL line k=%0d t=%0t {tx,busy,done,ready} got %b%b%b%b required %b%b%b%b",
                                     k, $time, txl[k], bsy[k], dne[k], rdy[k], e.tx, e.busy, e.done, e.rdy);
                        end
                    end
                end
            end
        join_none

        // reset state on every instance
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            push_rec(k, 1'b1, 1'b0, 1'b0, 1'b1);
            push_rec(k, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < N; k++) drain(k);

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].k, vecs[i].d, vecs[i].par, 1'b0);
            drain(vecs[i].k);
        end

        // back-to-back with valid held: one idle-high cycle between frames
        send(0, 8'h00, 1'b0, 1'b1);
        send(0, 8'hFF, 1'b0, 1'b0);
        drain(0);

        // reset during data bit 3, with a valid also present on the second reset edge
        @(posedge clk); #1;
        din[0] = 8'h55;
        vld[0] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        push_rec(0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_rec(0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_rec(0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_rec(0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_rec(0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 vld[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        vld[0] = 1'b1;
        din[0] = 8'hAA;
        push_rec(0, 1'b1, 1'b0, 1'b0, 1'b1);
        push_rec(0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        vld[0] = 1'b0;
        drain(0);
        send(0, 8'h81, 1'b0, 1'b0);
        drain(0);

        // valid toggled while busy must neither raise ready nor queue a frame
        send(3, 8'hC3, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (rdy[3] !== 1'b0) begin
                failures++;
                $display("FAIL busy_ready k=3 tx_ready=%b required 0", rdy[3]);
            end
            vld[3] = i[0];
        end
        vld[3] = 1'b0;
        drain(3);
        #1;
        for (int i = 0; i < 6; i++) push_rec(3, 1'b1, 1'b0, 1'b0, 1'b1);
        drain(3);

        for (int k = 0; k < N; k++) begin
            checks++;
            if (ndone[k] != exp_done[k]) begin
                failures++;
                $display("FAIL done_count k=%0d got %0d required %0d", k, ndone[k], exp_done[k]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
